// File: rtl/turing_pkg.sv
// Shared encodings for the Turing engine: status codes, FSM states,
// rule-word field layout and head move directions.
package turing_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_OFFL  = 2'b01,
    ST_OFFR  = 2'b10,
    ST_LIMIT = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } fsm_t;

  // Rule word layout, LSB first: write_bit, move, next_state[SW-1:0], halt
  localparam int unsigned RF_WBIT = 0;
  localparam int unsigned RF_MOVE = 1;
  localparam int unsigned RF_NEXT = 2;

  localparam logic MV_LEFT  = 1'b0;
  localparam logic MV_RIGHT = 1'b1;

  // Halt flag sits just above the next-state field
  function automatic int unsigned rf_halt_pos(input int unsigned sw);
    return RF_NEXT + sw;
  endfunction

endpackage

// File: rtl/turing_rule_table.sv
// Transition-rule register file indexed by {state, symbol}.
// Synchronous write and clear, combinational read.
module turing_rule_table
  import turing_pkg::*;
#(
  parameter int unsigned NSTATES = 4,
  parameter int unsigned SW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW:0]   waddr,
  input  logic [SW+2:0] wdata,
  input  logic [SW:0]   raddr,
  output logic [SW+2:0] rdata
);

  localparam int unsigned DEPTH = 2 * NSTATES;

  logic [SW+2:0] mem [DEPTH];

  // Table storage: cleared on reset, written on strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/turing_seq.sv
// Programmable single-tape Turing engine: loads tape/head on start, applies
// one rule per clock until halt, off-tape or step limit, then reports.
module turing_seq
  import turing_pkg::*;
#(
  parameter int unsigned TAPE_W  = 10,
  parameter int unsigned NSTATES = 4,
  parameter int unsigned SW      = $clog2(NSTATES),
  parameter int unsigned HW      = $clog2(TAPE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SW:0]       cfg_addr,
  input  logic [SW+2:0]     cfg_wdata,
  input  logic              start,
  input  logic [TAPE_W-1:0] tape_in,
  input  logic [HW-1:0]     head_init,
  input  logic [15:0]       step_limit,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [TAPE_W-1:0] tape_out,
  output logic [HW-1:0]     head_out,
  output logic [15:0]       steps_out
);

  localparam int unsigned   RW       = SW + 3;
  localparam int unsigned   RF_HALT  = rf_halt_pos(SW);
  localparam logic [HW-1:0] HEAD_MAX = HW'(TAPE_W - 1);

  fsm_t              fsm, fsm_nx;
  status_t           st, st_nx;
  logic [TAPE_W-1:0] tape, tape_nx;
  logic [HW-1:0]     head, head_nx;
  logic [SW-1:0]     state, state_nx;
  logic [15:0]       steps, steps_nx, steps_inc;
  logic [15:0]       limit, limit_nx;
  logic [RW-1:0]     rule;
  logic              sym, table_we;
  logic              r_halt, r_move, r_wbit;
  logic [SW-1:0]     r_next;

  // Configuration writes are only accepted while idle
  assign table_we = cfg_we && (fsm == S_IDLE);
  assign sym      = tape[head];

  turing_rule_table #(
    .NSTATES(NSTATES),
    .SW     (SW)
  ) u_rules (
    .clk  (clk),
    .rst  (rst),
    .we   (table_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr({state, sym}),
    .rdata(rule)
  );

  assign r_wbit = rule[RF_WBIT];
  assign r_move = rule[RF_MOVE];
  assign r_next = rule[RF_NEXT +: SW];
  assign r_halt = rule[RF_HALT];

  // Next-state logic: launch, single step with prioritised end checks, report
  always_comb begin
    fsm_nx    = fsm;
    st_nx     = st;
    tape_nx   = tape;
    head_nx   = head;
    state_nx  = state;
    steps_nx  = steps;
    limit_nx  = limit;
    steps_inc = (steps == '1) ? steps : steps + 16'd1;
    unique case (fsm)
      S_IDLE: begin
        if (start) begin
          tape_nx  = tape_in;
          head_nx  = (head_init > HEAD_MAX) ? HEAD_MAX : head_init;
          state_nx = '0;
          steps_nx = '0;
          limit_nx = step_limit;
          fsm_nx   = S_RUN;
        end
      end
      S_RUN: begin
        tape_nx[head] = r_wbit;
        steps_nx      = steps_inc;
        if (r_halt) begin
          st_nx  = ST_HALT;
          fsm_nx = S_DONE;
        end else if (r_move == MV_LEFT && head == '0) begin
          st_nx  = ST_OFFL;
          fsm_nx = S_DONE;
        end else if (r_move == MV_RIGHT && head == HEAD_MAX) begin
          st_nx  = ST_OFFR;
          fsm_nx = S_DONE;
        end else begin
          head_nx  = (r_move == MV_RIGHT) ? head + 1'b1 : head - 1'b1;
          state_nx = r_next;
          // Saturated step counter also ends the run as a limit stop
          if ((limit != '0 && steps_inc == limit) || steps_inc == '1) begin
            st_nx  = ST_LIMIT;
            fsm_nx = S_DONE;
          end
        end
      end
      S_DONE:  fsm_nx = S_IDLE;
      default: fsm_nx = S_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= S_IDLE;
      st    <= ST_HALT;
      tape  <= '0;
      head  <= '0;
      state <= '0;
      steps <= '0;
      limit <= '0;
    end else begin
      fsm   <= fsm_nx;
      st    <= st_nx;
      tape  <= tape_nx;
      head  <= head_nx;
      state <= state_nx;
      steps <= steps_nx;
      limit <= limit_nx;
    end
  end

  assign busy      = (fsm != S_IDLE);
  assign done      = (fsm == S_DONE);
  assign status    = st;
  assign tape_out  = tape;
  assign head_out  = head;
  assign steps_out = steps;

endmodule

// File: tb/tb_turing_seq.sv
// Directed self-checking bench for turing_seq with an expected-result queue.
module tb_turing_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [4:0]  cfg_wdata;
  logic        start;
  logic [9:0]  tape_in;
  logic [3:0]  head_init;
  logic [15:0] step_limit;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [9:0]  tape_out;
  logic [3:0]  head_out;
  logic [15:0] steps_out;

  int ncomp = 0;
  int nfail = 0;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] steps;
    logic [3:0]  head;
    logic [9:0]  tape;
    int          lat;
  } exp_t;

  exp_t sb[$];

  turing_seq #(.TAPE_W(10), .NSTATES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .tape_in   (tape_in),
    .head_init (head_init),
    .step_limit(step_limit),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .tape_out  (tape_out),
    .head_out  (head_out),
    .steps_out (steps_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rule(input logic [2:0] a, input logic [4:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_program();
    write_rule(3'd0, 5'b00010); // S0/0 -> w0,+1,S0
    write_rule(3'd1, 5'b00111); // S0/1 -> w1,+1,S1
    write_rule(3'd2, 5'b01011); // S1/0 -> w1,+1,S2
    write_rule(3'd3, 5'b00111); // S1/1 -> w1,+1,S1
    write_rule(3'd4, 5'b01100); // S2/0 -> w0,-1,S3
    write_rule(3'd5, 5'b01011); // S2/1 -> w1,+1,S2
    write_rule(3'd6, 5'b10000); // S3/x -> halt,w0
    write_rule(3'd7, 5'b10000);
  endtask

  // Launch one run, optionally poking start/cfg_we while busy, then score it
  task automatic run(input string tag, input logic [9:0] tp, input logic [3:0] hd,
                     input logic [15:0] lim, input bit inject, input exp_t e);
    exp_t got;
    int cyc;
    sb.push_back(e);
    tape_in = tp; head_init = hd; step_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, busy, 1);
    if (inject && !done) begin
      start = 1'b1; tape_in = '0; head_init = '0; step_limit = 16'd1;
      cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 5'b00010;
      tick();
      start = 1'b0; cfg_we = 1'b0;
      cyc++;
    end
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    got = sb.pop_front();
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, cyc, got.lat);
    check({tag, "_status"}, status, got.st);
    check({tag, "_steps"}, steps_out, got.steps);
    check({tag, "_head"}, head_out, got.head);
    check({tag, "_tape"}, tape_out, got.tape);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_hold_tape"}, tape_out, got.tape);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    tape_in = '0; head_init = '0; step_limit = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_tape", tape_out, 0);
    check("rst_head", head_out, 0);
    check("rst_steps", steps_out, 0);

    load_program();

    run("halt", 10'b00_1111_0110, 4'd0, 16'd0, 1'b0,
        '{st: 2'b00, steps: 16'd10, head: 4'd7, tape: 10'h07E, lat: 11});
    run("offr", 10'h3FE, 4'd0, 16'd0, 1'b0,
        '{st: 2'b10, steps: 16'd10, head: 4'd9, tape: 10'h3FE, lat: 11});
    run("limit", 10'b00_1111_0110, 4'd0, 16'd5, 1'b0,
        '{st: 2'b11, steps: 16'd5, head: 4'd5, tape: 10'h0FE, lat: 6});
    // Out-of-range head starts on the rightmost cell and walks off at once
    run("clamp", 10'h3FE, 4'd15, 16'd0, 1'b0,
        '{st: 2'b10, steps: 16'd1, head: 4'd9, tape: 10'h3FE, lat: 2});
    run("busy_ign", 10'b00_1111_0110, 4'd0, 16'd0, 1'b1,
        '{st: 2'b00, steps: 16'd10, head: 4'd7, tape: 10'h07E, lat: 11});
    run("readback", 10'b00_1111_0110, 4'd0, 16'd0, 1'b0,
        '{st: 2'b00, steps: 16'd10, head: 4'd7, tape: 10'h07E, lat: 11});

    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_rule(3'd0, 5'b00001); // S0/0 -> w1,-1,S0
    run("offl", 10'h000, 4'd0, 16'd0, 1'b0,
        '{st: 2'b01, steps: 16'd1, head: 4'd0, tape: 10'h001, lat: 2});

    load_program();
    tape_in = 10'b00_1111_0110; head_init = '0; step_limit = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy, 1);
    check("mid_steps", steps_out, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_status", status, 0);
    check("abort_tape", tape_out, 0);
    check("abort_head", head_out, 0);
    check("abort_steps", steps_out, 0);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    // A cleared table means S0/0 writes 0 and moves left off the tape
    run("zeroed", 10'h000, 4'd0, 16'd0, 1'b0,
        '{st: 2'b01, steps: 16'd1, head: 4'd0, tape: 10'h000, lat: 2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
